// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/piso_shreg.sv
// Parallel-load, right-shift, zero-fill shift register presenting its LSB.
module piso_shreg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             lsb
);

  logic [WIDTH-1:0] data;

  // Load takes priority over shift; zeros enter from the MSB side.
  always_ff @(posedge clk) begin
    if (reset) begin
      data <= '0;
    end else if (load) begin
      data <= din;
    end else if (shift) begin
      data <= data >> 1;
    end
  end

  assign lsb = data[0];

endmodule

// File: rtl/serial_add_ctrl.sv
// Operand sequencer and result collector around an external bit-serial adder.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             sa_clr,
  output logic             sa_x,
  output logic             sa_y,
  input  logic             sa_s
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   result;
  logic             accept;
  logic             shifting;
  logic             last_bit;
  logic             ar_lsb;
  logic             br_lsb;

  assign accept   = (state == IDLE) && in_valid;
  assign shifting = (state == SHIFT);
  assign last_bit = shifting && (cnt == CNT_W'(WIDTH));

  // Operand shift registers feeding the adder LSB-first.
  piso_shreg #(.WIDTH(WIDTH)) u_ar (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .shift (shifting),
    .din   (a),
    .lsb   (ar_lsb)
  );

  piso_shreg #(.WIDTH(WIDTH)) u_br (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .shift (shifting),
    .din   (b),
    .lsb   (br_lsb)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = CLEAR;
      CLEAR:   state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake and adder drive decoded from the current state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    sa_clr    = reset;
    sa_x      = 1'b0;
    sa_y      = 1'b0;
    case (state)
      IDLE:  in_ready = 1'b1;
      CLEAR: sa_clr = 1'b1;
      SHIFT: begin
        // Operands are fully drained by the carry-out cycle, so x=y=0 there.
        sa_x = ar_lsb;
        sa_y = br_lsb;
      end
      DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // Bit counter: restarts in CLEAR, advances once per serial bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (state == CLEAR) begin
      cnt <= '0;
    end else if (shifting && !last_bit) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Result SIPO: serial sum enters at the MSB; holds through DONE/IDLE.
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      result <= '0;
    end else if (shifting) begin
      result <= {sa_s, result[WIDTH:1]};
    end
  end

  assign sum = result;

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Operand sequencer and result collector for the team's bit-serial adder (serial x/y inputs, combinational serial sum s, one carry flip-flop with synchronous clear). It accepts two parallel WIDTH-bit operands over a valid/ready handshake and clears the adder's carry. It then streams the operands LSB-first into the adder, shifts the serial sum back into a parallel register, and presents a WIDTH+1-bit result (carry-out in the MSB) over a second valid/ready handshake.

## Interface
Parameters:
- WIDTH, 8, operand width in bits (≥1)

Ports (reset reset, synchronous, active-high; clock clk):
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  operand pair a/b valid
- in_ready  out  1  block accepts operands; high only in IDLE
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- out_valid  out  1  sum valid; high only in DONE
- out_ready  in  1  consumer takes sum
- sum  out  WIDTH+1  a+b, bit WIDTH = carry-out
- sa_clr  out  1  drives adder reset (carry clear)
- sa_x  out  1  serial bit to adder x
- sa_y  out  1  serial bit to adder y
- sa_s  in  1  serial sum from adder s (combinational in same cycle)

## Operation
- FSM states: IDLE, CLEAR, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid: load a into shift register ar, b into br, clear result register, go CLEAR.
- CLEAR: one cycle, sa_clr=1, sa_x=sa_y=0. The adder carry becomes 0 at the end of this cycle. Go SHIFT with bit counter cnt=0.
- SHIFT: sa_x=ar[0], sa_y=br[0]. Each edge: ar, br shift right with 0 fill; sa_s is shifted into the result MSB (result shifts right); cnt++. The cycle with cnt==WIDTH drives x=y=0, so sa_s equals the adder carry and is captured as sum[WIDTH]. After that edge, go DONE.
- DONE: out_valid=1, sum stable. On out_ready, go IDLE. The result register holds its value until the next accept.
- sa_clr = reset | (state==CLEAR). sa_x=sa_y=0 in all states other than SHIFT.
- in_valid is ignored outside IDLE. a/b are sampled only on the accepting edge.
- Arithmetic is unsigned modulo 2^(WIDTH+1); no overflow flag. cnt width is $clog2(WIDTH+1).

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, sum=0, sa_clr=1 while reset high, sa_x=sa_y=0, cnt=0, ar=br=0.
- Latency: accept at edge E0 → CLEAR during E0..E1 → SHIFT for WIDTH+1 cycles → out_valid high after edge E(WIDTH+2).
- Minimum op period: WIDTH+4 cycles (accept, CLEAR, WIDTH+1 SHIFT, DONE with out_ready=1). There is no accept in the DONE→IDLE cycle.
- out_valid held with sum stable until out_ready is sampled high. out_valid may stay high indefinitely.
- Reset mid-operation (any state): next edge goes to IDLE and clears sum. The in-flight result is discarded; sa_clr clears the adder.
- in_valid and reset together: reset wins; no accept.
- The adder carry left over from a previous operation never leaks, because CLEAR always precedes bit 0.

## Structure
- Package serial_add_pkg: state enum typedef (IDLE, CLEAR, SHIFT, DONE), default WIDTH constant.
- Sub-module piso_shreg (parallel-load, right-shift, zero-fill, WIDTH param), instantiated twice for ar/br. The result SIPO, counter and FSM are inline.
- The bench instantiates serial_add_ctrl together with the team's bit-serial adder, wired sa_x→x, sa_y→y, sa_clr→reset, s→sa_s.

## Test plan
- WIDTH=8, a=0x05, b=0x03, out_ready=1 → out_valid rises 10 edges after accept, sum=9'h008. sa_clr high exactly 1 cycle before the first bit.
- a=0xFF, b=0x01 → sum=9'h100. Then a=0x00, b=0x00 back-to-back → sum=9'h000 (carry cleared between ops).
- a=0xFF, b=0xFF with out_ready=0 for 5 cycles after out_valid → sum=9'h1FE held stable, out_valid stays high, in_ready=0. out_ready=1 → IDLE next cycle.
- in_valid pulsed during SHIFT with a=0xAA → ignored; in-flight result unchanged.
- reset asserted at cnt=4 of a=0x7F+0x7F → next cycle IDLE, sum=0, out_valid=0. Next op 0x12+0x34 → 9'h046.
- Random a/b, 1000 ops, random out_ready/in_valid gaps → every sum equals a+b (WIDTH+1 bits), no lost or duplicated results.
